hdmi_tmds_decode: RTL

HDMI_TMDS_DECODE -- requirements
Module: hdmi_tmds_decode

---
 rtl/hdmi_tmds_decode.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/hdmi_tmds_decode.sv
// One TMDS channel decoder: classifies aligned 10-bit symbols, tracks the
// control-run / guard-band preamble and emits decoded video bytes one clock later.
module hdmi_tmds_decode #(
  parameter logic [3:0] MIN_CTL = 4'd8,
  parameter logic [9:0] GUARD   = 10'h2cc
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [4:0]  i_sync,
  input  logic [9:0]  i_pix,
  output logic        o_valid,
  output logic [1:0]  o_type,
  output logic [1:0]  o_ctl,
  output logic [7:0]  o_data,
  output logic        o_de,
  output logic        o_err,
  output logic [15:0] o_err_count
);

  localparam logic [1:0] T_CTL = 2'b00;
  localparam logic [1:0] T_GRD = 2'b01;
  localparam logic [1:0] T_VID = 2'b10;
  localparam logic [1:0] T_INV = 2'b11;

  typedef enum logic [1:0] {NOSYNC, CTRL, GUARD1, VIDEO} state_t;

  state_t      state, state_nxt;
  logic [3:0]  run, run_nxt;
  logic        valid_nxt, de_nxt, err_nxt;
  logic [1:0]  type_nxt, ctl_nxt, ctl_sym;
  logic [7:0]  data_nxt;
  logic [15:0] err_count_nxt;
  logic        is_ctl, is_guard;
  logic        sync_offset_unused;

  // The aligner's bit offset is consumed upstream; only its valid flag matters here.
  assign sync_offset_unused = ^i_sync[3:0];

  function automatic logic [7:0] tmds_video(input logic [9:0] q);
    logic [7:0] dp;
    logic [7:0] d;
    dp   = q[9] ? ~q[7:0] : q[7:0];
    d    = '0;
    d[0] = dp[0];
    for (int i = 1; i < 8; i++)
      d[i] = q[8] ? (dp[i] ^ dp[i-1]) : ~(dp[i] ^ dp[i-1]);
    return d;
  endfunction

  function automatic logic [3:0] run_inc(input logic [3:0] r);
    return (r == 4'hf) ? r : r + 4'd1;
  endfunction

  function automatic logic [15:0] cnt_sat(input logic [15:0] c, input logic inc);
    return (inc && c != 16'hffff) ? c + 16'd1 : c;
  endfunction

  always_comb begin
    is_ctl  = 1'b1;
    ctl_sym = 2'b00;
    case (i_pix)
      10'h354: ctl_sym = 2'b00;
      10'h0ab: ctl_sym = 2'b01;
      10'h154: ctl_sym = 2'b10;
      10'h2ab: ctl_sym = 2'b11;
      default: is_ctl  = 1'b0;
    endcase
  end

  assign is_guard = (i_pix == GUARD);

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    valid_nxt = 1'b1;
    type_nxt  = T_INV;
    ctl_nxt   = o_ctl;
    data_nxt  = o_data;
    de_nxt    = 1'b0;
    err_nxt   = 1'b0;
    if (!i_sync[4]) begin
      state_nxt = NOSYNC;
      run_nxt   = '0;
      valid_nxt = 1'b0;
    end else begin
      case (state)
        NOSYNC: begin
          if (is_ctl) begin
            state_nxt = CTRL;
            run_nxt   = 4'd1;
            type_nxt  = T_CTL;
            ctl_nxt   = ctl_sym;
          end else begin
            valid_nxt = 1'b0;
          end
        end
        CTRL: begin
          if (is_ctl) begin
            run_nxt  = run_inc(run);
            type_nxt = T_CTL;
            ctl_nxt  = ctl_sym;
          end else if (is_guard && run >= MIN_CTL) begin
            state_nxt = GUARD1;
            type_nxt  = T_GRD;
          end else begin
            err_nxt = 1'b1;
            run_nxt = '0;
          end
        end
        GUARD1: begin
          if (is_guard) begin
            state_nxt = VIDEO;
            type_nxt  = T_GRD;
          end else begin
            state_nxt = CTRL;
            run_nxt   = '0;
            err_nxt   = 1'b1;
          end
        end
        VIDEO: begin
          // A guard symbol inside the video period is ordinary pixel data.
          if (is_ctl) begin
            state_nxt = CTRL;
            run_nxt   = 4'd1;
            type_nxt  = T_CTL;
            ctl_nxt   = ctl_sym;
          end else begin
            type_nxt = T_VID;
            data_nxt = tmds_video(i_pix);
            de_nxt   = 1'b1;
          end
        end
        default: state_nxt = NOSYNC;
      endcase
    end
    err_count_nxt = cnt_sat(o_err_count, err_nxt);
  end

  // Output stage: every field registered one clock after its input symbol.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= NOSYNC;
      run         <= '0;
      o_valid     <= 1'b0;
      o_type      <= T_INV;
      o_ctl       <= '0;
      o_data      <= '0;
      o_de        <= 1'b0;
      o_err       <= 1'b0;
      o_err_count <= '0;
    end else begin
      state       <= state_nxt;
      run         <= run_nxt;
      o_valid     <= valid_nxt;
      o_type      <= type_nxt;
      o_ctl       <= ctl_nxt;
      o_data      <= data_nxt;
      o_de        <= de_nxt;
      o_err       <= err_nxt;
      o_err_count <= err_count_nxt;
    end
  end

endmodule
